banked_memory: RTL and testbench

Parametrised multi-lane synchronous-read memory for weight and activation storage in the accelerator datapath. Each word holds LANES independent BIT_SIZE lanes with per-lane write masking. Adds a read-valid pipeline, an optional output register stage, write-first bypass on address collision, and a hardware clear sequencer that zeroes the array after reset or on command.

---
 rtl/banked_memory.sv | 134 +++++++++++++
 tb/tb_banked_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_memory.sv
// Multi-lane synchronous-read memory with per-lane write masking, write-first
// bypass on address collision, optional output register, and a zero-fill sequencer.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | normal operation; reads and writes accepted
//   S_CLEAR | zero-filling word[r_cnt] each cycle; reads/writes ignored
module banked_memory #(
   parameter int DEPTH          = 4,
   parameter int BIT_SIZE       = 8,
   parameter int LANES          = 4,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_start,
   output logic                      busy,
   input  logic                      write_enable,
   input  logic [LANES-1:0]          write_mask,
   input  logic [DEPTH-1:0]          write_addr,
   input  logic [LANES*BIT_SIZE-1:0] data_in,
   input  logic                      read_enable,
   input  logic [DEPTH-1:0]          read_addr,
   output logic [LANES*BIT_SIZE-1:0] data_out,
   output logic                      read_valid
);

   localparam int WORDS = 2 ** DEPTH;
   localparam int W     = LANES * BIT_SIZE;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t           r_state, w_state_nxt;
   logic [DEPTH-1:0] r_cnt, w_cnt_nxt;
   logic             r_pend, w_pend_nxt;
   logic [W-1:0]     r_mem [WORDS];

   logic             w_idle, w_wr, w_rd;
   logic [W-1:0]     w_rd_word, w_rd_data;
   logic [W-1:0]     r_d1;
   logic             r_v1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      case (r_state)
         S_IDLE: begin
            if (clear_start || r_pend) begin
               w_state_nxt = S_CLEAR;
               w_pend_nxt  = 1'b0;
            end
         end
         S_CLEAR: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == {DEPTH{1'b1}}) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_pend re-arms on every reset so an aborted clear restarts from word 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pend  <= (CLEAR_ON_RESET != 0);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   assign busy   = (r_state == S_CLEAR);
   assign w_idle = (r_state == S_IDLE) && !rst;
   assign w_wr   = w_idle && write_enable;
   assign w_rd   = w_idle && read_enable;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr) begin
            for (int i = 0; i < LANES; i++) begin
               if (write_mask[i]) r_mem[write_addr][i*BIT_SIZE +: BIT_SIZE] <= data_in[i*BIT_SIZE +: BIT_SIZE];
            end
         end
      end
   end

   // Write-first bypass: lanes being written this cycle return the incoming data
   assign w_rd_word = r_mem[read_addr];
   always_comb begin
      w_rd_data = w_rd_word;
      for (int i = 0; i < LANES; i++) begin
         if (w_wr && (write_addr == read_addr) && write_mask[i])
            w_rd_data[i*BIT_SIZE +: BIT_SIZE] = data_in[i*BIT_SIZE +: BIT_SIZE];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= w_rd;
         if (w_rd) r_d1 <= w_rd_data;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [W-1:0] r_d2;
         logic         r_v2;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_d2 <= '0;
               r_v2 <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_d2 <= r_d1;
            end
         end
         assign data_out   = r_d2;
         assign read_valid = r_v2;
      end else begin : g_no_out_reg
         assign data_out   = r_d1;
         assign read_valid = r_v1;
      end
   endgenerate

endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench for banked_memory: latency-1 and latency-2 instances share
// stimulus; a behavioural model predicts busy, read_valid and read data.
module tb_banked_memory;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clear_start, write_enable, read_enable;
   logic [3:0]  write_mask, write_addr, read_addr;
   logic [31:0] data_in;
   logic        busy0, busy1, rv0, rv1;
   logic [31:0] do0, do1;

   banked_memory #(.OUT_REG(0)) u_dut0 (
      .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy0),
      .write_enable(write_enable), .write_mask(write_mask), .write_addr(write_addr),
      .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr),
      .data_out(do0), .read_valid(rv0)
   );

   banked_memory #(.OUT_REG(1)) u_dut1 (
      .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy1),
      .write_enable(write_enable), .write_mask(write_mask), .write_addr(write_addr),
      .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr),
      .data_out(do1), .read_valid(rv1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] m_mem [16];
   bit          m_busy, m_pend, exp_v0, exp_v1;
   int          m_cnt;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   task automatic idle_inputs();
      clear_start  = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      write_mask   = 4'h0;
      write_addr   = 4'h0;
      read_addr    = 4'h0;
      data_in      = 32'h0;
   endtask

   // one clock: update the model with the inputs seen at the edge, then check
   task automatic cycle();
      logic [31:0] rd;
      bit          acc;
      @(posedge clk);
      acc = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_cnt  = 0;
         m_pend = 1'b1;
         q0.delete();
         q1.delete();
      end else if (m_busy) begin
         m_mem[m_cnt] = 32'h0;
         if (m_cnt == 15) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         if (read_enable) begin
            rd = m_mem[read_addr];
            if (write_enable && write_addr == read_addr)
               for (int i = 0; i < 4; i++) if (write_mask[i]) rd[i*8 +: 8] = data_in[i*8 +: 8];
            acc = 1'b1;
            q0.push_back(rd);
            q1.push_back(rd);
         end
         if (write_enable)
            for (int i = 0; i < 4; i++) if (write_mask[i]) m_mem[write_addr][i*8 +: 8] = data_in[i*8 +: 8];
         if (clear_start || m_pend) begin
            m_busy = 1'b1;
            m_pend = 1'b0;
         end
      end
      exp_v1 = rst ? 1'b0 : exp_v0;
      exp_v0 = acc;
      #1;
      chk("busy0", {31'b0, busy0}, {31'b0, m_busy});
      chk("busy1", {31'b0, busy1}, {31'b0, m_busy});
      chk("rvalid0", {31'b0, rv0}, {31'b0, exp_v0});
      chk("rvalid1", {31'b0, rv1}, {31'b0, exp_v1});
      if (rv0) begin
         if (q0.size() == 0) chk("q0_underflow", 32'(q0.size()), 32'd1);
         else chk("data0", do0, q0.pop_front());
      end
      if (rv1) begin
         if (q1.size() == 0) chk("q1_underflow", 32'(q1.size()), 32'd1);
         else chk("data1", do1, q1.pop_front());
      end
   endtask

   task automatic count_busy(input string tag);
      int nb = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (busy0) nb++;
      end
      chk(tag, 32'(nb), 32'd16);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         read_enable = 1'b1;
         read_addr   = 4'(i);
         cycle();
         chk(tag, do0, 32'h0);
      end
      read_enable = 1'b0;
      cycle();
      cycle();
   endtask

   initial begin
      int nv;
      logic [5:0] pat0, pat1;
      idle_inputs();
      m_busy = 1'b0; m_pend = 1'b0; m_cnt = 0; exp_v0 = 1'b0; exp_v1 = 1'b0;

      // reset and automatic clear
      rst = 1'b1;
      cycle();
      cycle();
      chk("rst_dout0", do0, 32'h0);
      chk("rst_dout1", do1, 32'h0);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      rst = 1'b0;
      count_busy("auto_clear_len");
      read_all_zero("auto_clear_rd");

      // masked write
      write_enable = 1'b1; write_addr = 4'd3; data_in = 32'hAABBCCDD; write_mask = 4'b0101;
      cycle();
      idle_inputs();
      read_enable = 1'b1; read_addr = 4'd3;
      cycle();
      chk("mask_wr", do0, 32'h00BB00DD);
      idle_inputs();
      cycle();
      cycle();

      // collision bypass
      write_enable = 1'b1; write_addr = 4'd5; data_in = 32'h11223344; write_mask = 4'hF;
      cycle();
      data_in = 32'hFFEEDDCC; write_mask = 4'b1100;
      read_enable = 1'b1; read_addr = 4'd5;
      cycle();
      chk("bypass", do0, 32'hFFEE3344);
      write_enable = 1'b0;
      cycle();
      chk("bypass_persist", do0, 32'hFFEE3344);
      idle_inputs();
      cycle();
      cycle();

      // pipeline latency with reads on t=0,1,3
      for (int i = 0; i < 6; i++) begin
         write_enable = 1'b1; write_mask = 4'hF; write_addr = 4'(8 + i);
         data_in = 32'hC0DE0000 + 32'(i * 17 + 1);
         cycle();
      end
      idle_inputs();
      for (int t = 0; t < 6; t++) begin
         read_enable = (t == 0 || t == 1 || t == 3);
         read_addr   = 4'(8 + t);
         cycle();
         pat0[t] = rv0;
         pat1[t] = rv1;
      end
      idle_inputs();
      chk("lat1_pattern", {26'b0, pat0}, 32'b001011);
      chk("lat2_pattern", {26'b0, pat1}, 32'b010110);
      cycle();

      // clear blocks reads and writes
      write_enable = 1'b1; write_addr = 4'd2; data_in = 32'h5A5A5A5A; write_mask = 4'hF;
      cycle();
      idle_inputs();
      clear_start = 1'b1;
      cycle();
      clear_start = 1'b0;
      nv = 0;
      for (int k = 0; k < 20 && busy0; k++) begin
         write_enable = 1'b1; write_addr = 4'd2; data_in = 32'h12345678; write_mask = 4'hF;
         read_enable = 1'b1; read_addr = 4'd2;
         cycle();
         if (rv0 || rv1) nv++;
      end
      idle_inputs();
      chk("blk_no_valid", 32'(nv), 32'd0);
      chk("blk_busy_done", {31'b0, busy0}, 32'd0);
      read_enable = 1'b1; read_addr = 4'd2;
      cycle();
      chk("blk_wr_dropped", do0, 32'h0);
      idle_inputs();
      cycle();
      cycle();

      // reset in the middle of a clear
      for (int i = 0; i < 16; i++) begin
         write_enable = 1'b1; write_mask = 4'hF; write_addr = 4'(i);
         data_in = 32'h01010101 * 32'(i + 1);
         cycle();
      end
      idle_inputs();
      clear_start = 1'b1;
      cycle();
      clear_start = 1'b0;
      repeat (6) cycle();
      rst = 1'b1;
      cycle();
      chk("midclr_busy", {31'b0, busy0}, 32'd0);
      rst = 1'b0;
      count_busy("midclr_restart_len");
      read_all_zero("midclr_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
